// File: rtl/word_pkg.sv
// Shared definitions for the word packer/unpacker pair: default word size,
// the two-state handshake FSM encoding and the half-word even-parity function.
package word_pkg;

  localparam int BYTES_DEF = 8;

  // Widest word the parity helper handles (BYTES up to 32).
  localparam int PAR_MAX_W = 256;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Even parity of one half of a word; the word is zero-extended to PAR_MAX_W.
  function automatic logic half_parity(input logic [PAR_MAX_W-1:0] w,
                                       input int unsigned         half_bits,
                                       input logic                upper);
    logic [PAR_MAX_W-1:0] s;
    logic [PAR_MAX_W-1:0] mask;
    s    = upper ? (w >> half_bits) : w;
    mask = {PAR_MAX_W{1'b1}} >> (PAR_MAX_W - half_bits);
    return ^(s & mask);
  endfunction

endpackage

// File: rtl/unpack_parity.sv
// Combinational check of both half-word parity bits against a packed word.
module unpack_parity
  import word_pkg::*;
#(
  parameter int BYTES = BYTES_DEF
) (
  input  logic [8*BYTES-1:0] word,
  input  logic               check1,
  input  logic               check2,
  output logic               mismatch
);

  localparam int unsigned HALF_W = 4 * BYTES;

  logic [PAR_MAX_W-1:0] word_ext;
  logic                 p1;
  logic                 p2;

  assign word_ext = PAR_MAX_W'(word);
  assign p1       = half_parity(word_ext, HALF_W, 1'b0);
  assign p2       = half_parity(word_ext, HALF_W, 1'b1);
  assign mismatch = (p1 != check1) || (p2 != check2);

endmodule

// File: rtl/word_unpacker.sv
// Accepts a parity-checked packed word and streams it out LSB byte first.
// Build option UNPACK_ERR_DROP_EN: words failing the check are counted but discarded.
module word_unpacker
  import word_pkg::*;
#(
  parameter int BYTES     = BYTES_DEF,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic [8*BYTES-1:0]   wordIn,
  input  logic                 check1In,
  input  logic                 check2In,
  input  logic                 wordValid,
  output logic                 wordReady,
  output logic [7:0]           dataOut,
  output logic                 dataValid,
  input  logic                 dataReady,
  input  logic                 clearErr,
  output logic                 parityError,
  output logic [ERR_CNT_W-1:0] errCount
);

  localparam int W     = 8 * BYTES;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t               state;
  state_t               state_nxt;
  logic [W-1:0]         data_p1;
  logic                 vld_p1;
  logic                 rdy_q;
  logic [IDX_W-1:0]     idx;
  logic                 mismatch;
  logic                 accept;
  logic                 byte_done;
  logic                 load;
  logic                 err_hit;
  logic                 perr_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  unpack_parity #(
    .BYTES (BYTES)
  ) u_parity (
    .word     (wordIn),
    .check1   (check1In),
    .check2   (check2In),
    .mismatch (mismatch)
  );

  assign accept    = wordValid && rdy_q;
  assign byte_done = vld_p1 && dataReady;
  assign err_hit   = accept && mismatch;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef UNPACK_ERR_DROP_EN
          if (!mismatch) begin
            state_nxt = SEND;
            load      = 1'b1;
          end
`else
          state_nxt = SEND;
          load      = 1'b1;
`endif
        end
      end
      SEND: begin
        if (byte_done && (idx == LAST_IDX)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: control registers; ready/valid are flopped so neither has a
  // combinational path from the handshake inputs.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state  <= IDLE;
      rdy_q  <= 1'b1;
      vld_p1 <= 1'b0;
      idx    <= '0;
    end else begin
      state  <= state_nxt;
      rdy_q  <= (state_nxt == IDLE);
      vld_p1 <= (state_nxt == SEND);
      if (load) begin
        idx <= '0;
      end else if (byte_done) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Stage p1: byte shift register; zero fill leaves dataOut at 0 once drained.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      data_p1 <= '0;
    end else if (load) begin
      data_p1 <= wordIn;
    end else if (byte_done) begin
      data_p1 <= data_p1 >> 8;
    end
  end

  // A clear coinciding with a failing word keeps the new error.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      perr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else if (clearErr) begin
      perr_q    <= err_hit;
      err_cnt_q <= err_hit ? ERR_CNT_W'(1) : '0;
    end else if (err_hit) begin
      perr_q    <= 1'b1;
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign wordReady   = rdy_q;
  assign dataValid   = vld_p1;
  assign dataOut     = data_p1[7:0];
  assign parityError = perr_q;
  assign errCount    = err_cnt_q;

endmodule

// File: doc/word_unpacker.md
Name: word_unpacker

Overview:
- Inverse of the byte-packing checker: takes a 64-bit word plus its two check bits and streams it back out as bytes.
- Verifies both check bits on acceptance, then emits bytes LSB-first over a valid/ready interface.
- Sits between the packed-word domain (checkData/check1/check2 producers) and any byte-wide consumer; the bench loops packer output back through this block.

Parameters:
- BYTES, 8, bytes per word; word width = 8*BYTES; must be even, at least 2.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clock  input  1  single system clock, rising edge.
- clear_n  input  1  reset, asynchronous assert, active-low.
- wordIn  input  8*BYTES  packed data word.
- check1In  input  1  even parity of the low half, wordIn[4*BYTES-1:0].
- check2In  input  1  even parity of the high half, wordIn[8*BYTES-1:4*BYTES].
- wordValid  input  1  wordIn/check bits valid.
- wordReady  output  1  block can accept a word.
- dataOut  output  8  current output byte.
- dataValid  output  1  dataOut valid.
- dataReady  input  1  consumer accepts dataOut.
- clearErr  input  1  synchronous clear of parityError and errCount.
- parityError  output  1  sticky: a check mismatch was seen.
- errCount  output  ERR_CNT_W  saturating count of mismatched words.

Behaviour:
- Reset (clear_n low, any time, including mid-word):
  - dataOut=0, dataValid=0, wordReady=1, parityError=0, errCount=0.
  - State goes to IDLE; any partially sent word is discarded.
- State machine has two states, IDLE and SEND.
- wordReady is 1 exactly when state is IDLE; it is registered, with no combinational path from wordValid.
- IDLE:
  - On wordValid&&wordReady, the block latches wordIn into a shift register and computes p1=^wordIn[low half] and p2=^wordIn[high half].
  - Mismatch is defined as (p1!=check1In)||(p2!=check2In).
  - It then moves to SEND with byte index 0.
- SEND:
  - dataValid=1 and dataOut = byte[index], where byte 0 = wordIn[7:0].
  - dataOut holds stable while dataValid&&!dataReady.
  - On dataValid&&dataReady: if index<BYTES-1, index+1 and the next byte appears the following cycle; if index==BYTES-1, go to IDLE (dataValid=0, wordReady=1 the next cycle).
- Latency: word accepted at edge N gives first byte valid after edge N; with dataReady tied high, each word takes BYTES+1 cycles.
- Error logic:
  - On an accepted mismatching word, parityError is set and errCount increments.
  - errCount saturates at all-ones and never wraps.
- clearErr:
  - Clears both error outputs at the next edge.
  - If it coincides with a mismatching accept, the result is parityError=1, errCount=1 (the new error wins).
- wordValid while in SEND is ignored; the upstream must hold the word until wordReady.

Optional Feature:
- Macro: UNPACK_ERR_DROP_EN.
- Defined: a mismatching word is still accepted (wordReady handshake completes) and counted, but it is discarded. The block stays in IDLE, no bytes are emitted, and wordReady stays 1.
- Undefined: mismatching words are counted and flagged, and all BYTES bytes are still emitted.

Decomposition:
- Shared package word_pkg holds:
  - default BYTES constant;
  - state enum {IDLE, SEND};
  - a half-word parity function, so the packer and unpacker share the same definition.
- One natural sub-module, unpack_parity: combinational; takes the word and both check bits and outputs mismatch. It is reused by the bench scoreboard.

Test Plan:
- Reset mid-word: reset held low 3 cycles, then released; accept a word and release clear_n low after 3 bytes -> dataValid=0, wordReady=1 and errCount=0 on the next edge; the next word restarts at byte 0.
- Good word, dataReady=1: wordIn=64'h0123456789ABCDEF, check1In=0, check2In=0 -> bytes EF,CD,AB,89,67,45,23,01 on 8 consecutive cycles; parityError=0; wordReady returns to 1 on cycle 9.
- Backpressure: word 64'hAAAAAAAAAAAAAAAA (checks 0,0), dataReady toggled 1,0,0,1,... -> 8 bytes of AA, each held stable while stalled; no byte lost or duplicated.
- Bad check: 64'h0123456789ABCDEF with check1In=1 -> parityError=1, errCount=1.
  - Without the macro, all 8 bytes are still emitted.
  - With UNPACK_ERR_DROP_EN, no dataValid pulse occurs and wordReady stays 1.
- Saturation and clear: 260 bad words -> errCount=8'hFF; then clearErr pulse -> parityError=0, errCount=0. clearErr coincident with a bad accept -> errCount=1.
- Loopback: packer fed dataIn=8'hAA for 20 cycles; its checkData/check1/check2 drive this block -> output byte stream equals the input stream and parityError=0.
